// File: rtl/melody_pkg.sv
// Shared FSM state type and song ROM word layout for the melody sequencer.
// Word layout, MSB first: {last, dur, note}.
package melody_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam int NUM_SONGS = 4;
  localparam int SONG_W    = $clog2(NUM_SONGS);

  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 3;
  localparam int NOTE_OFS  = 0;
  localparam int DUR_OFS   = NOTE_OFS + NOTE_W;
  localparam int LAST_OFS  = DUR_OFS + DUR_W;
  localparam int WORD_W    = LAST_OFS + 1;

  typedef logic [WORD_W-1:0] rom_word_t;

  function automatic rom_word_t mk_word(input logic [NOTE_W-1:0] note,
                                        input logic [DUR_W-1:0]  dur,
                                        input logic              last);
    return {last, dur, note};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song ROM: {song, step} -> {last, dur, note}; no latency, no backpressure.
// Unused addresses return a rest with last set so a stray read always terminates.
module song_rom
  import melody_pkg::*;
#(
  parameter int IDX_BW = 6
) (
  input  logic [SONG_W-1:0] i_song,
  input  logic [IDX_BW-1:0] i_step,
  output rom_word_t         o_word
);

  always_comb begin
    o_word = mk_word('0, '0, 1'b1);
    case (i_song)
      2'd0: begin
        case (int'(i_step))
          0:       o_word = mk_word(6'd13, 3'd1, 1'b0);
          1:       o_word = mk_word(6'd0,  3'd0, 1'b0);
          2:       o_word = mk_word(6'd15, 3'd2, 1'b0);
          3:       o_word = mk_word(6'd17, 3'd0, 1'b0);
          4:       o_word = mk_word(6'd0,  3'd1, 1'b1);
          default: o_word = mk_word('0, '0, 1'b1);
        endcase
      end
      2'd1: begin
        case (int'(i_step))
          0:       o_word = mk_word(6'd20, 3'd0, 1'b0);
          1:       o_word = mk_word(6'd22, 3'd1, 1'b0);
          2:       o_word = mk_word(6'd0,  3'd1, 1'b0);
          3:       o_word = mk_word(6'd25, 3'd3, 1'b1);
          default: o_word = mk_word('0, '0, 1'b1);
        endcase
      end
      // Full-length descending run with no last flag: ends only at the final step.
      2'd2: begin
        o_word = mk_word(NOTE_W'(63 - int'(i_step)), DUR_W'(i_step[1:0]), 1'b0);
      end
      2'd3: begin
        if (int'(i_step) < 8) begin
          o_word = mk_word(NOTE_W'(int'(i_step) + 1), DUR_W'(i_step), i_step == IDX_BW'(7));
        end
      end
      default: o_word = mk_word('0, '0, 1'b1);
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a ROM song on tempo strobes and emits registered note/gate/step/busy/done.
// Outputs lag internal state by one cycle; en_i low freezes the sequencer, no other backpressure.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int IDX_BW  = 6,
  parameter int SEQ_LEN = 64,
  parameter int DUR_BW  = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              strb_i,
  input  logic              play_i,
  input  logic              loop_i,
  input  logic [1:0]        song_sel_i,
  output logic [IDX_BW-1:0] noteIndex_o,
  output logic              gate_o,
  output logic [IDX_BW-1:0] step_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_play_q;
  logic [SONG_W-1:0]   r_song;
  logic [SONG_W-1:0]   w_song_nxt;
  logic [IDX_BW-1:0]   r_step;
  logic [IDX_BW-1:0]   w_step_nxt;
  logic [DUR_BW-1:0]   r_rem;
  logic [DUR_BW-1:0]   w_rem_nxt;
  logic [DUR_BW-1:0]   w_rem_d;
  logic                w_load;
  logic                w_done_evt;
  logic                r_done_evt;
  logic                w_start;
  logic                w_end;

  rom_word_t           w_cur_word;
  rom_word_t           w_nxt_word;
  logic [IDX_BW-1:0]   w_cur_note;
  logic                w_cur_last;
  logic [DUR_BW-1:0]   w_nxt_dur;
  logic                w_unused_bits;

  // One ROM port reads the current step, the other the step being entered.
  song_rom #(.IDX_BW(IDX_BW)) u_rom_cur (
    .i_song (r_song),
    .i_step (r_step),
    .o_word (w_cur_word)
  );

  song_rom #(.IDX_BW(IDX_BW)) u_rom_nxt (
    .i_song (w_song_nxt),
    .i_step (w_step_nxt),
    .o_word (w_nxt_word)
  );

  assign w_cur_note    = IDX_BW'(w_cur_word[NOTE_OFS +: NOTE_W]);
  assign w_cur_last    = w_cur_word[LAST_OFS];
  assign w_nxt_dur     = DUR_BW'(w_nxt_word[DUR_OFS +: DUR_W]);
  assign w_unused_bits = ^{w_cur_word[DUR_OFS +: DUR_W], w_nxt_word[NOTE_OFS +: NOTE_W],
                           w_nxt_word[LAST_OFS]};

  assign w_start = play_i & ~r_play_q;
  assign w_end   = w_cur_last | (r_step == IDX_BW'(SEQ_LEN - 1));
  assign w_rem_d = w_load ? w_nxt_dur : w_rem_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_song_nxt  = r_song;
    w_step_nxt  = r_step;
    w_rem_nxt   = r_rem;
    w_load      = 1'b0;
    w_done_evt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && en_i) begin
          w_state_nxt = ST_PLAY;
          w_song_nxt  = song_sel_i;
          w_step_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      ST_PLAY: begin
        if (en_i) begin
          // Abort has priority over a strobe arriving in the same cycle.
          if (!play_i) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = '0;
            w_rem_nxt   = '0;
          end else if (strb_i) begin
            if (r_rem != '0) begin
              w_rem_nxt = r_rem - DUR_BW'(1);
            end else if (w_end) begin
              w_step_nxt = '0;
              if (loop_i) begin
                w_load = 1'b1;
              end else begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = '0;
                w_done_evt  = 1'b1;
              end
            end else begin
              w_step_nxt = r_step + IDX_BW'(1);
              w_load     = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_play_q   <= 1'b0;
      r_song     <= '0;
      r_step     <= '0;
      r_rem      <= '0;
      r_done_evt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_play_q   <= play_i;
      r_song     <= w_song_nxt;
      r_step     <= w_step_nxt;
      r_rem      <= w_rem_d;
      r_done_evt <= w_done_evt;
    end
  end

  // Output stage: done is delayed alongside the state so it coincides with busy falling.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      noteIndex_o <= '0;
      gate_o      <= 1'b0;
      step_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      noteIndex_o <= (r_state == ST_PLAY) ? w_cur_note : '0;
      gate_o      <= (r_state == ST_PLAY) && (w_cur_note != '0);
      step_o      <= (r_state == ST_PLAY) ? r_step : '0;
      busy_o      <= (r_state == ST_PLAY);
      done_o      <= r_done_evt;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: vector table, directed corner sequences and random play
// checked cycle by cycle against a flattened-song reference model.
module tb_melody_sequencer;

  localparam int IDX_BW  = 6;
  localparam int SEQ_LEN = 64;
  localparam int DUR_BW  = 3;

  logic              clk_i = 1'b0;
  logic              rst_n_i, en_i, strb_i, play_i, loop_i;
  logic [1:0]        song_sel_i;
  logic [IDX_BW-1:0] noteIndex_o, step_o;
  logic              gate_o, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  melody_sequencer #(.IDX_BW(IDX_BW), .SEQ_LEN(SEQ_LEN), .DUR_BW(DUR_BW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .strb_i      (strb_i),
    .play_i      (play_i),
    .loop_i      (loop_i),
    .song_sel_i  (song_sel_i),
    .noteIndex_o (noteIndex_o),
    .gate_o      (gate_o),
    .step_o      (step_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Song contents as data: song 3 is the test scale, others are the shipped tunes.
  function automatic int t_note(input int s, input int k);
    case (s)
      0: case (k) 0: return 13; 2: return 15; 3: return 17; default: return 0; endcase
      1: case (k) 0: return 20; 1: return 22; 3: return 25; default: return 0; endcase
      2: return 63 - k;
      default: return k + 1;
    endcase
  endfunction

  function automatic int t_dur(input int s, input int k);
    case (s)
      0: case (k) 0: return 1; 2: return 2; 4: return 1; default: return 0; endcase
      1: case (k) 1: return 1; 2: return 1; 3: return 3; default: return 0; endcase
      2: return k % 4;
      default: return k;
    endcase
  endfunction

  function automatic bit t_last(input int s, input int k);
    case (s)
      0: return k == 4;
      1: return k == 3;
      2: return 1'b0;
      default: return k == 7;
    endcase
  endfunction

  // Each song unrolled into one entry per strobe; a counted strobe advances one entry.
  int flat[4][256];
  int flat_len[4];

  function automatic void build();
    int n;
    for (int s = 0; s < 4; s++) begin
      n = 0;
      for (int k = 0; k < SEQ_LEN; k++) begin
        for (int r = 0; r <= t_dur(s, k); r++) begin
          flat[s][n] = k;
          n++;
        end
        if (t_last(s, k)) break;
      end
      flat_len[s] = n;
    end
  endfunction

  bit m_play, m_play_q, m_done_evt;
  int m_song, m_pos;

  function automatic void model_reset();
    m_play = 0; m_play_q = 0; m_done_evt = 0; m_song = 0; m_pos = 0;
  endfunction

  function automatic void model_update();
    m_done_evt = 0;
    if (!m_play) begin
      if (play_i && !m_play_q && en_i) begin
        m_play = 1; m_song = int'(song_sel_i); m_pos = 0;
      end
    end else if (en_i) begin
      if (!play_i) begin
        m_play = 0;
      end else if (strb_i) begin
        m_pos++;
        if (m_pos == flat_len[m_song]) begin
          m_pos = 0;
          if (!loop_i) begin
            m_play = 0; m_done_evt = 1;
          end
        end
      end
    end
    m_play_q = play_i;
  endfunction

  int done_cnt = 0;
  bit busy_prev = 0;
  bit rest_seen = 0;
  bit log_en = 0;
  int note_log[$];

  task automatic tick();
    int e_note, e_step;
    bit e_busy, e_gate, e_done;
    @(posedge clk_i);
    e_busy = m_play;
    e_step = m_play ? flat[m_song][m_pos] : 0;
    e_note = m_play ? t_note(m_song, e_step) : 0;
    e_gate = e_busy && (e_note != 0);
    e_done = m_done_evt;
    if (!rst_n_i) model_reset();
    else model_update();
    @(negedge clk_i);
    chk("model_note", 32'(noteIndex_o), 32'(e_note));
    chk("model_step", 32'(step_o), 32'(e_step));
    chk("model_gate", 32'(gate_o), 32'(e_gate));
    chk("model_busy", 32'(busy_o), 32'(e_busy));
    chk("model_done", 32'(done_o), 32'(e_done));
    if (done_o) begin
      done_cnt++;
      chk("done_with_busy_low", 32'(busy_o), 32'd0);
      chk("done_busy_was_high", 32'(busy_prev), 32'd1);
    end
    if (busy_o && !gate_o) rest_seen = 1;
    if (log_en && busy_o && (note_log.size() == 0 || note_log[note_log.size()-1] != int'(noteIndex_o)))
      note_log.push_back(int'(noteIndex_o));
    busy_prev = busy_o;
  endtask

  task automatic start_song(input logic [1:0] s, input logic lp);
    en_i = 1; strb_i = 0; loop_i = lp; play_i = 0;
    tick();
    play_i = 1; song_sel_i = s;
    tick();
    tick();
  endtask

  task automatic strobe_pair();
    strb_i = 1; tick();
    strb_i = 0; tick();
  endtask

  typedef struct {
    bit en, strb, play, loop;
    bit [1:0] sel;
    int note, step;
    bit gate, busy, done;
  } vec_t;

  vec_t vt[13];
  int   hist[64];
  int   nstrb;
  bit   saw63;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build();
    model_reset();
    en_i = 1; strb_i = 0; play_i = 0; loop_i = 0; song_sel_i = 2'd3;
    rst_n_i = 1;
    #2 rst_n_i = 0;
    #1;
    chk("rst_note", 32'(noteIndex_o), 32'd0);
    chk("rst_gate", 32'(gate_o), 32'd0);
    chk("rst_step", 32'(step_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    tick(); tick();
    rst_n_i = 1;

    // Start song 3, walk two steps, freeze with en low, then abort.
    vt[0]  = '{1,0,0,0,2'd3, 0,0,0,0,0};
    vt[1]  = '{1,0,1,0,2'd3, 0,0,0,0,0};
    vt[2]  = '{1,0,1,0,2'd3, 1,0,1,1,0};
    vt[3]  = '{1,1,1,0,2'd3, 1,0,1,1,0};
    vt[4]  = '{1,0,1,0,2'd3, 2,1,1,1,0};
    vt[5]  = '{1,1,1,0,2'd3, 2,1,1,1,0};
    vt[6]  = '{1,1,1,0,2'd3, 2,1,1,1,0};
    vt[7]  = '{1,0,1,0,2'd3, 3,2,1,1,0};
    vt[8]  = '{0,1,1,0,2'd3, 3,2,1,1,0};
    vt[9]  = '{0,1,1,0,2'd3, 3,2,1,1,0};
    vt[10] = '{1,0,0,0,2'd3, 3,2,1,1,0};
    vt[11] = '{1,0,0,0,2'd3, 0,0,0,0,0};
    vt[12] = '{1,0,0,0,2'd3, 0,0,0,0,0};
    for (int i = 0; i < 13; i++) begin
      en_i = vt[i].en; strb_i = vt[i].strb; play_i = vt[i].play;
      loop_i = vt[i].loop; song_sel_i = vt[i].sel;
      tick();
      chk("vec_note", 32'(noteIndex_o), 32'(vt[i].note));
      chk("vec_step", 32'(step_o), 32'(vt[i].step));
      chk("vec_gate", 32'(gate_o), 32'(vt[i].gate));
      chk("vec_busy", 32'(busy_o), 32'(vt[i].busy));
      chk("vec_done", 32'(done_o), 32'(vt[i].done));
    end

    // One-shot song 3, one strobe every 10 cycles.
    for (int k = 0; k < 64; k++) hist[k] = 0;
    note_log.delete();
    done_cnt = 0; nstrb = 0; log_en = 1;
    start_song(2'd3, 1'b0);
    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      if (c % 10 == 9) begin
        strb_i = 1; nstrb++;
        if (busy_o) hist[int'(step_o)]++;
      end else begin
        strb_i = 0;
      end
      tick();
    end
    strb_i = 0; log_en = 0;
    chk("oneshot_strobes", 32'(nstrb), 32'd36);
    for (int k = 0; k < 8; k++) chk("oneshot_step_len", 32'(hist[k]), 32'(k + 1));
    chk("oneshot_note_cnt", 32'(note_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < note_log.size(); k++)
      chk("oneshot_note_walk", 32'(note_log[k]), 32'(k + 1));
    repeat (20) tick();
    chk("oneshot_done_once", 32'(done_cnt), 32'd1);
    chk("no_restart_held", 32'(busy_o), 32'd0);
    play_i = 0; tick();
    play_i = 1; tick(); tick();
    chk("retrig_busy", 32'(busy_o), 32'd1);
    chk("retrig_step", 32'(step_o), 32'd0);
    chk("retrig_note", 32'(noteIndex_o), 32'd1);
    play_i = 0; tick(); tick();

    // Loop song 3: wrap back to step 0 without done.
    done_cnt = 0;
    start_song(2'd3, 1'b1);
    for (int i = 0; i < 36; i++) begin
      if (i == 35) chk("loop_pre_wrap_step", 32'(step_o), 32'd7);
      strobe_pair();
    end
    chk("loop_wrap_step", 32'(step_o), 32'd0);
    chk("loop_wrap_note", 32'(noteIndex_o), 32'd1);
    chk("loop_wrap_busy", 32'(busy_o), 32'd1);
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    play_i = 0; tick(); tick();

    // Abort at step 3 coincident with a strobe.
    done_cnt = 0;
    start_song(2'd3, 1'b0);
    for (int c = 0; c < 50 && step_o != 6'd3; c++) begin
      strb_i = 1; tick();
    end
    chk("abort_reach_step3", 32'(step_o), 32'd3);
    play_i = 0; strb_i = 1; tick();
    strb_i = 0; tick();
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_step", 32'(step_o), 32'd0);
    repeat (5) tick();
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // Enable freeze partway through step 2.
    start_song(2'd3, 1'b0);
    repeat (4) strobe_pair();
    chk("freeze_at_step2", 32'(step_o), 32'd2);
    en_i = 0;
    repeat (5) strobe_pair();
    chk("freeze_hold", 32'(step_o), 32'd2);
    en_i = 1;
    strobe_pair();
    chk("freeze_resume_hold", 32'(step_o), 32'd2);
    strobe_pair();
    chk("freeze_resume_adv", 32'(step_o), 32'd3);
    play_i = 0; tick(); tick();

    // Rest note gates off while busy.
    rest_seen = 0;
    start_song(2'd0, 1'b0);
    repeat (10) strobe_pair();
    chk("rest_gate_low", 32'(rest_seen), 32'd1);
    play_i = 0; tick(); tick();

    // Song with no last flag ends at the final step.
    done_cnt = 0; saw63 = 0;
    start_song(2'd2, 1'b0);
    strb_i = 1;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      tick();
      if (busy_o && step_o == 6'd63) saw63 = 1;
    end
    strb_i = 0;
    chk("maxlen_saw_step63", 32'(saw63), 32'd1);
    chk("maxlen_done", 32'(done_cnt), 32'd1);
    play_i = 0; tick(); tick();

    // Randomized play/abort/enable/loop activity.
    for (int c = 0; c < 4000; c++) begin
      if (play_i) begin
        if ($urandom_range(149) == 0) play_i = 0;
      end else begin
        if ($urandom_range(7) == 0) play_i = 1;
      end
      strb_i = ($urandom_range(2) == 0);
      en_i   = ($urandom_range(9) != 0);
      if ($urandom_range(49) == 0) loop_i = ~loop_i;
      song_sel_i = 2'($urandom_range(3));
      tick();
    end

    // Reset mid-song drops outputs immediately.
    start_song(2'd3, 1'b0);
    repeat (3) begin strb_i = 1; tick(); end
    strb_i = 0; tick();
    chk("rstmid_pre_busy", 32'(busy_o), 32'd1);
    rst_n_i = 0;
    #1;
    chk("rstmid_note", 32'(noteIndex_o), 32'd0);
    chk("rstmid_gate", 32'(gate_o), 32'd0);
    chk("rstmid_step", 32'(step_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_done", 32'(done_o), 32'd0);
    model_reset();
    play_i = 0;
    tick(); tick();
    rst_n_i = 1;
    tick(); tick();
    chk("rstmid_idle_busy", 32'(busy_o), 32'd0);
    chk("rstmid_idle_step", 32'(step_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Upstream stage of the tone path. It steps through a melody stored in an internal song ROM, paced by the tempo strobe. For each step it emits a registered note index, which the downstream notes ROM and PWM modulator turn into a tone. It also emits a gate that mutes the PWM output during rests. It adds per-note durations, song selection, start/stop control, one-shot or loop playback, and a completion pulse.

## Interface
- `IDX_BW`, 6: width of the note index and the step counter.
- `SEQ_LEN`, 64: maximum number of steps per song.
- `DUR_BW`, 3: width of the per-step duration field.
- `clk_i`  in  1: system clock.
- `rst_n_i`  in  1: reset. One clock; reset is asynchronous and active-low.
- `en_i`  in  1: global enable. While low, strobes are ignored and state is held.
- `strb_i`  in  1: tempo tick from the strobe generator. Single-cycle pulse.
- `play_i`  in  1: level. A rising edge starts playback; low aborts it.
- `loop_i`  in  1: sampled at end of song. 1 = restart at step 0, 0 = stop.
- `song_sel_i`  in  2: song number. Latched only at start.
- `noteIndex_o`  out  IDX_BW: current note index. 0 = rest.
- `gate_o`  out  1: high while playing a non-rest note.
- `step_o`  out  IDX_BW: current step number.
- `busy_o`  out  1: high while in PLAY.
- `done_o`  out  1: one-cycle pulse on natural end of a one-shot song.

## Operation
- ROM word per {song, step}: note[IDX_BW-1:0], dur[DUR_BW-1:0], last. A step lasts dur+1 counted strobes.
- Song 3 is the fixed test scale:
  - steps 0..7 → note = step+1, dur = step;
  - last = 1 at step 7.
- `play_q` is a registered copy of `play_i`. start = `play_i` & ~`play_q`.
- FSM states: IDLE, PLAY.
- IDLE:
  - outputs are 0;
  - on start with `en_i`=1: latch `song_sel_i`, step = 0, remaining = dur(step 0), go to PLAY.
- PLAY, counted strobe = `strb_i` & `en_i`:
  - if remaining > 0: decrement remaining;
  - else, if the current step has last = 1 or step = SEQ_LEN-1, it is the end of song:
    - `loop_i`=1: step = 0, reload;
    - `loop_i`=0: go to IDLE and pulse `done_o`.
  - otherwise (not end of song): step+1, remaining = dur of the new step.
- PLAY, `play_i`=0: abort to IDLE. No `done_o`. Abort wins over a simultaneous strobe.
- `play_i` held high after a natural end does not restart. A new rising edge is required.
- `en_i` low in PLAY freezes step and remaining. Outputs hold.
- Output decode:
  - `noteIndex_o` = ROM note in PLAY, 0 in IDLE;
  - `gate_o` = PLAY & (note ≠ 0);
  - `busy_o` = PLAY.
- The remaining counter is DUR_BW wide and never underflows. The step counter wraps only through the loop rule.

## Timing
- All outputs are registered. After reset every output is 0 and the FSM is in IDLE.
- Start latency: `play_i` rises at edge N (sampled at edge N). `busy_o`, `gate_o`, `noteIndex_o` and `step_o` are valid after edge N+1.
- A step-advancing strobe sampled at edge M updates the outputs after edge M+1's output register, i.e. 1 cycle after the strobe.
- `done_o` is high in the same cycle that `busy_o` falls.
- Asserting reset mid-song takes effect immediately: all outputs drop to 0 asynchronously. Release resumes in IDLE.
- A `song_sel_i` change during PLAY has no effect until the next start.

## Structure
- Package `melody_pkg` holds:
  - the FSM state enum;
  - the ROM word layout: NOTE_W, DUR_W and the field offsets;
  - the NUM_SONGS = 4 constant.
- Sub-module `song_rom`: combinational, maps {song, step} to the ROM word. The contents of all 4 songs live there.
- The top of `melody_sequencer` contains:
  - the FSM;
  - the step and remaining counters;
  - the `play_i` edge register;
  - the output registers.

## Test plan
- Reset: assert `rst_n_i` low mid-PLAY → all outputs 0 immediately. After release, FSM in IDLE and `busy_o` = 0.
- One-shot song 3, `loop_i`=0, one strobe per 10 cycles:
  - `noteIndex_o` walks 1..8;
  - step k holds for k+1 strobes (36 strobes total);
  - `done_o` pulses once, `busy_o` falls the same cycle.
- Loop song 3, `loop_i`=1: after step 7 completes, `step_o` = 0 and `noteIndex_o` = 1 on the next strobe; `done_o` stays 0.
- Abort: drop `play_i` at step 3, coincident with a strobe → IDLE next cycle, `step_o` = 0, `done_o` never asserts.
- Enable freeze: `en_i`=0 for 5 strobes at step 2 → `step_o` stays 2; the remaining count resumes unchanged when `en_i` returns to 1.
- Rest and retrigger:
  - a song step with note 0 → `gate_o` = 0 while `busy_o` = 1;
  - `play_i` held high after `done_o` → no restart;
  - a new rising edge → restart at step 0.
